if_fetch_unit: RTL and testbench

- Instruction-fetch initiator for the 5-stage MIPS32 pipeline; drives the byte PC into the combinational instruction memory and captures the returned word into the IF/ID pipeline register.
- Owns PC sequencing (PC+4, branch/jump redirect), load-use stall hold, branch flush, and a halt state when the PC leaves the populated instruction window.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/if_fetch_unit_if.sv | 26 ++
 rtl/if_fetch_unit_if_id_reg.sv | 36 +++
 rtl/if_fetch_unit.sv | 94 +++++++++
 tb/tb_if_fetch_unit.sv | 119 +++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS32 fetch front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

   localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
   localparam logic [31:0] NOP_WORD_DEF   = 32'h0000_0000;
   localparam int unsigned IMEM_BYTES_DEF = 256;
   localparam logic [31:0] WORD_BYTES     = 32'd4;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_t;

   // Clears the byte-offset bits so a fetch address is always word aligned.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Bundle between the fetch unit, instruction memory, hazard unit and ID stage.
// Latency: n/a (wires only); instruction is returned combinationally for pc.
// Backpressure: stall from the hazard unit freezes fetch; redirect flushes it.
// Ports: master = fetch unit (drives pc and IF/ID outputs), slave = environment.
interface if_fetch_unit_if;
   logic [31:0] pc;
   logic [31:0] instruction;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_target;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic        halted;
   logic        misalign;

   modport master (
      output pc, if_id_instr, if_id_pc4, if_id_valid, halted, misalign,
      input  instruction, stall, redirect, redirect_target
   );

   modport slave (
      input  pc, if_id_instr, if_id_pc4, if_id_valid, halted, misalign,
      output instruction, stall, redirect, redirect_target
   );
endinterface

// File: rtl/if_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: instruction word, its pc+4 and a valid flag.
// Latency: one edge from load to outputs.
// Backpressure: holds when neither load nor flush; flush beats load.
// Ports: clk, reset (sync, active-high), load/flush controls, instr_in/pc4_in data,
//        instr/pc4/valid registered outputs.
module if_id_reg #(
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        flush,
   input  logic [31:0] instr_in,
   input  logic [31:0] pc4_in,
   output logic [31:0] instr,
   output logic [31:0] pc4,
   output logic        valid
);

   always_ff @(posedge clk) begin
      if (reset) begin
         instr <= NOP_WORD;
         pc4   <= 32'h0;
         valid <= 1'b0;
      end else if (flush) begin
         // pc4 is deliberately left alone: only the word and valid are squashed.
         instr <= NOP_WORD;
         valid <= 1'b0;
      end else if (load) begin
         instr <= instr_in;
         pc4   <= pc4_in;
         valid <= 1'b1;
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: PC sequencing, redirect/stall/halt control, feeds IF/ID.
// Latency: word at pc appears on if_id_instr one edge later; pc is always registered.
// Backpressure: stall holds pc and IF/ID; redirect overrides stall; HALT ignores stall.
// Ports: clk, reset (sync, active-high), f = master side of if_fetch_unit_if.
module if_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
   parameter int unsigned IMEM_BYTES = IMEM_BYTES_DEF,
   parameter logic [31:0] NOP_WORD   = NOP_WORD_DEF
) (
   input  logic            clk,
   input  logic            reset,
   if_fetch_unit_if.master f
);

   localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);

   fetch_state_t state_q, state_nxt;
   logic [31:0]  pc_q, pc_nxt;
   logic [31:0]  pc_plus4;
   logic         misalign_q;
   logic         ifid_load, ifid_flush;
   logic         out_of_window;
   logic [31:0]  ifid_instr, ifid_pc4;
   logic         ifid_valid;

   assign pc_plus4      = pc_q + WORD_BYTES;   // wraps modulo 2^32
   assign out_of_window = (pc_q >= IMEM_LIMIT);

   // State, pc and misalign registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= RUN;
         pc_q       <= RESET_PC;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         pc_q       <= pc_nxt;
         misalign_q <= f.redirect && (f.redirect_target[1:0] != 2'b00);
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state_q;
      unique case (state_q)
         RUN:     if (!f.redirect && !f.stall && out_of_window) state_nxt = HALT;
         HALT:    if (f.redirect) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   // Datapath controls: redirect > stall > (halt detect | advance).
   always_comb begin
      pc_nxt     = pc_q;
      ifid_load  = 1'b0;
      ifid_flush = 1'b0;
      if (f.redirect) begin
         pc_nxt     = word_align(f.redirect_target);
         ifid_flush = 1'b1;
      end else if (state_q == HALT) begin
         ifid_flush = 1'b1;
      end else if (f.stall) begin
         // hold everything
      end else if (out_of_window) begin
         // The out-of-window word is never allowed into IF/ID as valid.
         ifid_flush = 1'b1;
      end else begin
         pc_nxt    = pc_plus4;
         ifid_load = 1'b1;
      end
   end

   if_id_reg #(.NOP_WORD(NOP_WORD)) u_if_id_reg (
      .clk      (clk),
      .reset    (reset),
      .load     (ifid_load),
      .flush    (ifid_flush),
      .instr_in (f.instruction),
      .pc4_in   (pc_plus4),
      .instr    (ifid_instr),
      .pc4      (ifid_pc4),
      .valid    (ifid_valid)
   );

   assign f.pc          = pc_q;
   assign f.halted      = (state_q == HALT);
   assign f.misalign    = misalign_q;
   assign f.if_id_instr = ifid_instr;
   assign f.if_id_pc4   = ifid_pc4;
   assign f.if_id_valid = ifid_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: ROM word at byte address A is {16'hC0DE, A[15:0]}.
module tb_if_fetch_unit;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;

   if_fetch_unit_if fif();

   if_fetch_unit dut (
      .clk   (clk),
      .reset (reset),
      .f     (fif.master)
   );

   always #5 clk = ~clk;

   assign fif.instruction = (fif.pc < 32'd256) ? {16'hC0DE, fif.pc[15:0]} : 32'hDEAD_BEEF;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ifid(input string tag, input logic [31:0] pc_e, input logic [31:0] ins_e,
                           input logic [31:0] pc4_e, input logic v_e);
      chk({tag, ".pc"},    fif.pc,          pc_e);
      chk({tag, ".instr"}, fif.if_id_instr, ins_e);
      chk({tag, ".pc4"},   fif.if_id_pc4,   pc4_e);
      chk({tag, ".valid"}, 32'(fif.if_id_valid), 32'(v_e));
   endtask

   initial begin
      reset = 1'b1;
      fif.stall = 1'b0;
      fif.redirect = 1'b0;
      fif.redirect_target = 32'h0;
      step(); step();
      chk_ifid("rst", 32'h0, 32'h0, 32'h0, 1'b0);
      chk("rst.halted",   32'(fif.halted),   32'h0);
      chk("rst.misalign", 32'(fif.misalign), 32'h0);
      reset = 1'b0;

      // Free-running fetch.
      step(); chk_ifid("run1", 32'h4, 32'hC0DE_0000, 32'h4, 1'b1);
      step(); chk_ifid("run2", 32'h8, 32'hC0DE_0004, 32'h8, 1'b1);

      // Two-cycle stall at pc=8.
      fif.stall = 1'b1;
      step(); chk_ifid("stall1", 32'h8, 32'hC0DE_0004, 32'h8, 1'b1);
      step(); chk_ifid("stall2", 32'h8, 32'hC0DE_0004, 32'h8, 1'b1);
      fif.stall = 1'b0;
      step(); chk_ifid("run3", 32'hC,  32'hC0DE_0008, 32'hC,  1'b1);
      step(); chk_ifid("run4", 32'h10, 32'hC0DE_000C, 32'h10, 1'b1);

      // Redirect from pc=4 to 0x10.
      reset = 1'b1; step(); reset = 1'b0;
      step(); chk("pre_redir.pc", fif.pc, 32'h4);
      fif.redirect = 1'b1; fif.redirect_target = 32'h10;
      step(); chk_ifid("redir", 32'h10, 32'h0, 32'h4, 1'b0);
      chk("redir.misalign", 32'(fif.misalign), 32'h0);
      fif.redirect = 1'b0;
      step(); chk_ifid("post_redir", 32'h14, 32'hC0DE_0010, 32'h14, 1'b1);

      // Redirect beats a simultaneous stall.
      fif.redirect = 1'b1; fif.stall = 1'b1; fif.redirect_target = 32'h20;
      step(); chk_ifid("redir_stall", 32'h20, 32'h0, 32'h14, 1'b0);
      chk("redir_stall.misalign", 32'(fif.misalign), 32'h0);
      fif.redirect = 1'b0; fif.stall = 1'b0;
      step(); chk_ifid("post_rs", 32'h24, 32'hC0DE_0020, 32'h24, 1'b1);

      // Run up to the end of the window: (0x100-0x24)/4 = 55 edges.
      repeat (55) step();
      chk_ifid("edge_win", 32'h100, 32'hC0DE_00FC, 32'h100, 1'b1);
      chk("edge_win.halted", 32'(fif.halted), 32'h0);
      step(); chk_ifid("halt1", 32'h100, 32'h0, 32'h100, 1'b0);
      chk("halt1.halted", 32'(fif.halted), 32'h1);
      fif.stall = 1'b1;
      step(); step(); chk_ifid("halt_stall", 32'h100, 32'h0, 32'h100, 1'b0);
      chk("halt_stall.halted", 32'(fif.halted), 32'h1);
      fif.stall = 1'b0;
      step(); chk("halt3.halted", 32'(fif.halted), 32'h1);
      fif.redirect = 1'b1; fif.redirect_target = 32'h0;
      step(); chk_ifid("unhalt", 32'h0, 32'h0, 32'h100, 1'b0);
      chk("unhalt.halted", 32'(fif.halted), 32'h0);
      fif.redirect = 1'b0;
      step(); chk_ifid("resume", 32'h4, 32'hC0DE_0000, 32'h4, 1'b1);

      // Misaligned redirect target.
      fif.redirect = 1'b1; fif.redirect_target = 32'h0000_0006;
      step(); chk_ifid("mis", 32'h4, 32'h0, 32'h4, 1'b0);
      chk("mis.pulse", 32'(fif.misalign), 32'h1);
      fif.redirect = 1'b0;
      step(); chk_ifid("mis_after", 32'h8, 32'hC0DE_0004, 32'h8, 1'b1);
      chk("mis.clear", 32'(fif.misalign), 32'h0);

      // Reset while stalled.
      fif.stall = 1'b1;
      step(); chk("stall_hold.pc", fif.pc, 32'h8);
      reset = 1'b1;
      step(); chk_ifid("rst_stall", 32'h0, 32'h0, 32'h0, 1'b0);
      chk("rst_stall.halted", 32'(fif.halted), 32'h0);
      reset = 1'b0; fif.stall = 1'b0;
      step(); chk_ifid("rst_run", 32'h4, 32'hC0DE_0000, 32'h4, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
